video_timing_switcher: RTL
==========================

// Module: video_timing_switcher
// PURPOSE
//  Parametrised raster timing generator with run-time mode switching. Supersedes
//  the fixed-mode timing path. Drives the pixel counters, syncs and active flag
//  consumed by textgen/videogen/datagen. Mode changes are accepted by handshake
//  and take effect glitch-free at the next frame boundary.
// PARAMETERS
//  CW            12  width of counterX/counterY
//  NUM_MODES     3   valid mode indices 0..NUM_MODES-1 (max 4)
//  MODE_BITS     2   width of mode_sel/cur_mode
//  DEFAULT_MODE  1   mode loaded at reset
//  Mode table (active/fp/sync/bp, polarity):
//    0=480p  H 720/16/62/60 (tot 858),   V 480/9/6/30 (tot 525),  -H -V
//    1=720p  H 1280/110/40/220 (tot 1650), V 720/5/5/20 (tot 750),  +H +V
//    2=1080p H 1920/88/44/148 (tot 2200),  V 1080/4/5/36 (tot 1125), +H +V
// PORTS
//  clock        in   1          pixel clock
//  reset_n      in   1          synchronous, active-low reset
//  mode_sel     in   MODE_BITS  requested mode, sampled when mode_req=1
//  mode_req     in   1          1-cycle request strobe
//  mode_ack     out  1          1-cycle pulse: new mode applied (first pixel)
//  mode_err     out  1          1-cycle pulse: request rejected (invalid index)
//  mode_busy    out  1          a request is pending, not yet applied
//  cur_mode     out  MODE_BITS  mode currently being generated
//  counterX     out  CW         horizontal position, 0 = first active pixel
//  counterY     out  CW         vertical position, 0 = first active line
//  hsync        out  1          horizontal sync, mode polarity applied
//  vsync        out  1          vertical sync, mode polarity applied
//  state        out  1          1 = active video region
//  frame_start  out  1          1-cycle pulse with pixel (0,0)
// BEHAVIOUR
//  - All outputs are registered. hsync/vsync/state/frame_start describe the
//    pixel shown on counterX/counterY in the same cycle.
//  - Reset (reset_n=0 at edge): counterX=0, counterY=0, state=0, frame_start=0,
//    mode_ack=0, mode_err=0, mode_busy=0, cur_mode=DEFAULT_MODE, hsync/vsync at
//    DEFAULT_MODE inactive level. Any pending request is discarded.
//  - First edge with reset_n=1: pixel (0,0) presented, state=1, frame_start=1.
//  - Each cycle X increments. At X=HTOT-1, X wraps to 0 and Y increments.
//    At Y=VTOT-1 with X=HTOT-1, both wrap to 0 and frame_start=1.
//  - state=1 iff X<HACT and Y<VACT.
//  - hsync active iff HACT+HFP <= X < HACT+HFP+HSYNC.
//  - vsync active iff VACT+VFP <= Y < VACT+VFP+VSYNC. Whole lines, X-independent.
//  - Active level = 1 for + polarity, 0 for - polarity.
//  - Mode FSM, states IDLE/PENDING:
//    IDLE: mode_req with mode_sel<NUM_MODES -> latch pend_mode, go to PENDING,
//          mode_busy=1 from next cycle. mode_req with mode_sel>=NUM_MODES ->
//          mode_err pulse next cycle, stay IDLE.
//    PENDING: a valid mode_req overwrites pend_mode (last wins). An invalid
//          mode_req gives mode_err and keeps the old pend_mode.
//    PENDING at frame wrap: cur_mode<=pend_mode, counters (0,0) in new timing,
//          mode_ack=1 and frame_start=1 on that cycle, mode_busy=0, go to IDLE.
//          If mode_req coincides with the wrap cycle, the wrap applies the
//          previously latched mode and the new request leaves the FSM PENDING.
//  - A request for the current mode is still held and acked at the frame
//    boundary; the raster is unchanged.
//  - Counters never exceed HTOT-1/VTOT-1. A mid-frame switch never truncates
//    or extends a frame.
// TESTING
//  1. Reset, mode 1: counterX runs 0..1649 and wraps. hsync=1 for X 1390..1429.
//     vsync=1 for Y 725..729. frame_start every 1,237,500 cycles.
//  2. In mode 1, mode_req with sel=2 at (100,100): busy=1 until wrap; ack and
//     frame_start at the same cycle. Next frame is 2200x1125, hsync at X 2008..2051.
//  3. Switch to mode 0: hsync/vsync idle high, low for X 736..797 and
//     Y 489..494. state high only for X<720, Y<480.
//  4. mode_req sel=3 -> mode_err pulse, busy stays 0, cur_mode unchanged.
//     Then sel=0 then sel=2 within one frame -> single ack, cur_mode=2.
//  5. reset_n low mid-frame while PENDING -> next cycle counters 0, busy=0,
//     cur_mode=DEFAULT_MODE. After release: frame_start=1, no ack.
//  6. mode_req on the exact wrap cycle while PENDING(0) with sel=2 -> mode 0
//     applied with ack. busy stays 1. Mode 2 is applied at the following wrap.

Source files
------------

// File: rtl/video_timing_switcher.sv
// Raster timing generator with a small mode table and a request/ack mode
// switcher. A new mode is only committed on the frame wrap so the sink
// never sees a truncated or stretched frame.
module video_timing_switcher #(
    parameter int CW           = 12,
    parameter int NUM_MODES    = 3,
    parameter int MODE_BITS    = 2,
    parameter int DEFAULT_MODE = 1,
    // Mode table, entry [m] describes mode m. Entry 3 is unused padding.
    parameter logic [3:0][CW-1:0] H_ACT  = {12'd0, 12'd1920, 12'd1280, 12'd720},
    parameter logic [3:0][CW-1:0] H_FP   = {12'd0, 12'd88,   12'd110,  12'd16},
    parameter logic [3:0][CW-1:0] H_SYNC = {12'd0, 12'd44,   12'd40,   12'd62},
    parameter logic [3:0][CW-1:0] H_BP   = {12'd0, 12'd148,  12'd220,  12'd60},
    parameter logic [3:0][CW-1:0] V_ACT  = {12'd0, 12'd1080, 12'd720,  12'd480},
    parameter logic [3:0][CW-1:0] V_FP   = {12'd0, 12'd4,    12'd5,    12'd9},
    parameter logic [3:0][CW-1:0] V_SYNC = {12'd0, 12'd5,    12'd5,    12'd6},
    parameter logic [3:0][CW-1:0] V_BP   = {12'd0, 12'd36,   12'd20,   12'd30},
    // Sync polarity per mode: 1 = active high
    parameter logic [3:0]         H_POS  = 4'b0110,
    parameter logic [3:0]         V_POS  = 4'b0110
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [MODE_BITS-1:0] mode_sel,
    input  logic                 mode_req,
    output logic                 mode_ack,
    output logic                 mode_err,
    output logic                 mode_busy,
    output logic [MODE_BITS-1:0] cur_mode,
    output logic [CW-1:0]        counterX,
    output logic [CW-1:0]        counterY,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 state,
    output logic                 frame_start
);

    typedef enum logic {IDLE, PENDING} fsm_t;

    localparam logic [CW-1:0]        ONE   = 1;
    localparam logic [MODE_BITS-1:0] DEF_M = DEFAULT_MODE[MODE_BITS-1:0];
    localparam logic [MODE_BITS:0]   NM    = NUM_MODES[MODE_BITS:0];

    function automatic logic [CW-1:0] htot(input logic [MODE_BITS-1:0] m);
        return H_ACT[m] + H_FP[m] + H_SYNC[m] + H_BP[m];
    endfunction

    function automatic logic [CW-1:0] vtot(input logic [MODE_BITS-1:0] m);
        return V_ACT[m] + V_FP[m] + V_SYNC[m] + V_BP[m];
    endfunction

    fsm_t                 fsm_q;
    logic [MODE_BITS-1:0] cur_q, pend_q, nm;
    logic                 ack_q, err_q, busy_q;
    logic [CW-1:0]        x_q, y_q, x_d, y_d;
    logic                 st_q, st_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
    logic                 started_q;
    logic                 h_last, v_last, wrap, req_ok;
    logic [CW-1:0]        hs_beg, hs_end, vs_beg, vs_end;

    assign req_ok = ({1'b0, mode_sel} < NM);

    // Next pixel position and its attributes, in the timing of the mode that
    // will be live for that pixel (the pending mode on a committing wrap).
    always_comb begin
        h_last = (x_q == (htot(cur_q) - ONE));
        v_last = (y_q == (vtot(cur_q) - ONE));
        wrap   = started_q && h_last && v_last;
        nm     = (wrap && fsm_q == PENDING) ? pend_q : cur_q;
        x_d    = '0;
        y_d    = '0;
        if (started_q && !wrap) begin
            if (h_last) begin
                y_d = y_q + ONE;
            end else begin
                x_d = x_q + ONE;
                y_d = y_q;
            end
        end
        hs_beg = H_ACT[nm] + H_FP[nm];
        hs_end = hs_beg + H_SYNC[nm];
        vs_beg = V_ACT[nm] + V_FP[nm];
        vs_end = vs_beg + V_SYNC[nm];
        st_d   = (x_d < H_ACT[nm]) && (y_d < V_ACT[nm]);
        hs_d   = ((x_d >= hs_beg) && (x_d < hs_end)) ? H_POS[nm] : ~H_POS[nm];
        vs_d   = ((y_d >= vs_beg) && (y_d < vs_end)) ? V_POS[nm] : ~V_POS[nm];
        fs_d   = !started_q || wrap;
    end

    // Raster registers; the first edge out of reset presents pixel (0,0).
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            x_q       <= '0;
            y_q       <= '0;
            st_q      <= 1'b0;
            fs_q      <= 1'b0;
            hs_q      <= ~H_POS[DEF_M];
            vs_q      <= ~V_POS[DEF_M];
            started_q <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            st_q      <= st_d;
            fs_q      <= fs_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            started_q <= 1'b1;
        end
    end

    // Mode FSM. The wrap commit is written first so that a request in the
    // same cycle overrides fsm/pend/busy and stays pending for the next frame.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fsm_q  <= IDLE;
            cur_q  <= DEF_M;
            pend_q <= DEF_M;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (fsm_q == PENDING && wrap) begin
                cur_q  <= pend_q;
                ack_q  <= 1'b1;
                fsm_q  <= IDLE;
                busy_q <= 1'b0;
            end
            if (mode_req) begin
                if (req_ok) begin
                    pend_q <= mode_sel;
                    fsm_q  <= PENDING;
                    busy_q <= 1'b1;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign mode_ack    = ack_q;
    assign mode_err    = err_q;
    assign mode_busy   = busy_q;
    assign cur_mode    = cur_q;
    assign counterX    = x_q;
    assign counterY    = y_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign state       = st_q;
    assign frame_start = fs_q;

endmodule
